// File: rtl/data_mem_responder_if.sv
// Load/store bus between the execute stage (master) and the data memory (slave).
// A transfer happens on a rising edge where valid and ready are both high; valid holds its payload stable until then.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering RV32I loads/stores one at a time,
// with byte-lane steering, load extension, illegal-access flagging and wait states.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  data_mem_responder_if.slave       bus,
  output logic [1:0]                dbg_state
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        commit;
  logic        access_err;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [3:0]  lane_be;
  logic [31:0] wr_data;

  assign dbg_state = state;
  assign commit    = (state == ST_WAIT) && (cnt == 4'd0);
  assign rd_word   = mem[addr_q[AW+1:2]];
  assign rd_shift  = rd_word >> {addr_q[1:0], 3'b000};
  assign rd_half   = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  // LBU/LHU encodings are load-only, so using them for a store is illegal too.
  always_comb begin
    access_err = 1'b0;
    case (funct3_q)
      3'b000:  access_err = 1'b0;
      3'b001:  access_err = addr_q[0];
      3'b010:  access_err = |addr_q[1:0];
      3'b100:  access_err = we_q;
      3'b101:  access_err = we_q | addr_q[0];
      default: access_err = 1'b1;
    endcase
    if (|addr_q[31:AW+2]) access_err = 1'b1;
  end

  always_comb begin
    lane_be = 4'b1111;
    wr_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_be = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_be = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_be = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    load_data = 32'd0;
    case (funct3_q)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, rd_shift[7:0]};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = 32'd0;
    endcase
  end

  // Storage keeps its contents across reset; writes happen only on the commit edge.
  always_ff @(posedge clk) begin
    if (commit && we_q && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      we_q          <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      funct3_q      <= 3'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            we_q          <= bus.req_we;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            funct3_q      <= bus.req_funct3;
            // One access cycle plus WAIT_CYCLES wait states before the commit edge.
            cnt           <= 4'(WAIT_CYCLES);
            bus.req_ready <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (commit) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= access_err;
            bus.rsp_rdata <= (we_q || access_err) ? 32'd0 : load_data;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: begin
          bus.req_ready <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one main instance plus WAIT_CYCLES=0 and 3 instances for latency.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int WAIT_CYCLES = 1;

  logic clk;
  logic rst_n;

  int          sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_ready;

  logic        cur_req_ready;
  logic        cur_rsp_valid;
  logic [31:0] cur_rsp_rdata;
  logic        cur_rsp_err;
  logic [1:0]  cur_dbg;
  logic [1:0]  dbg_m, dbg_0, dbg_3;

  int n_checks;
  int n_errors;

  data_mem_responder_if bm ();
  data_mem_responder_if b0 ();
  data_mem_responder_if b3 ();

  assign bm.req_valid = req_valid && (sel == 0);
  assign b0.req_valid = req_valid && (sel == 1);
  assign b3.req_valid = req_valid && (sel == 2);
  assign bm.req_we = req_we;   assign b0.req_we = req_we;   assign b3.req_we = req_we;
  assign bm.req_addr = req_addr;   assign b0.req_addr = req_addr;   assign b3.req_addr = req_addr;
  assign bm.req_wdata = req_wdata; assign b0.req_wdata = req_wdata; assign b3.req_wdata = req_wdata;
  assign bm.req_funct3 = req_funct3; assign b0.req_funct3 = req_funct3; assign b3.req_funct3 = req_funct3;
  assign bm.rsp_ready = rsp_ready; assign b0.rsp_ready = rsp_ready; assign b3.rsp_ready = rsp_ready;

  assign cur_req_ready = (sel == 1) ? b0.req_ready : (sel == 2) ? b3.req_ready : bm.req_ready;
  assign cur_rsp_valid = (sel == 1) ? b0.rsp_valid : (sel == 2) ? b3.rsp_valid : bm.rsp_valid;
  assign cur_rsp_rdata = (sel == 1) ? b0.rsp_rdata : (sel == 2) ? b3.rsp_rdata : bm.rsp_rdata;
  assign cur_rsp_err   = (sel == 1) ? b0.rsp_err   : (sel == 2) ? b3.rsp_err   : bm.rsp_err;
  assign cur_dbg       = (sel == 1) ? dbg_0 : (sel == 2) ? dbg_3 : dbg_m;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bm), .dbg_state(dbg_m));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .dbg_state(dbg_0));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .dbg_state(dbg_3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request with rsp_ready=1 and checks data, error flag and latency.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int guard;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    rsp_ready = 1'b1;
    guard = 0;
    while (!cur_req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!cur_rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, cur_rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, cur_rsp_err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
  endtask

  localparam int L = 1 + WAIT_CYCLES;

  initial begin
    int guard;
    n_checks = 0;
    n_errors = 0;
    sel = 0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, cur_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, cur_rsp_valid}, 32'd0);
    check("rst_rsp_rdata", cur_rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, cur_rsp_err}, 32'd0);
    check("rst_state", {30'd0, cur_dbg}, 32'd0);

    // basic store/load and lane steering
    xact("sw10",  1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'd0, 1'b0, L);
    xact("lw10",  1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0, L);
    xact("sb11",  1'b1, 32'h11, 32'hAABBCC55, 3'b000, 32'd0, 1'b0, L);
    xact("lw10b", 1'b0, 32'h10, 32'd0, 3'b010, 32'hDEAD55EF, 1'b0, L);
    xact("lb13",  1'b0, 32'h13, 32'd0, 3'b000, 32'hFFFFFFDE, 1'b0, L);
    xact("lbu13", 1'b0, 32'h13, 32'd0, 3'b100, 32'h000000DE, 1'b0, L);
    xact("lh12",  1'b0, 32'h12, 32'd0, 3'b001, 32'hFFFFDEAD, 1'b0, L);
    xact("lhu10", 1'b0, 32'h10, 32'd0, 3'b101, 32'h000055EF, 1'b0, L);
    xact("lb11",  1'b0, 32'h11, 32'd0, 3'b000, 32'h00000055, 1'b0, L);
    xact("lh10",  1'b0, 32'h10, 32'd0, 3'b001, 32'h000055EF, 1'b0, L);

    // illegal accesses leave storage untouched
    xact("sw00",   1'b1, 32'h0,   32'h0BADF00D, 3'b010, 32'd0, 1'b0, L);
    xact("lw12e",  1'b0, 32'h12,  32'd0, 3'b010, 32'd0, 1'b1, L);
    xact("sh11e",  1'b1, 32'h11,  32'h0000FFFF, 3'b001, 32'd0, 1'b1, L);
    xact("f011e",  1'b0, 32'h10,  32'd0, 3'b011, 32'd0, 1'b1, L);
    xact("sbue",   1'b1, 32'h10,  32'h00000000, 3'b100, 32'd0, 1'b1, L);
    xact("lwoore", 1'b0, 32'(4*DEPTH), 32'd0, 3'b010, 32'd0, 1'b1, L);
    xact("swoore", 1'b1, 32'(4*DEPTH), 32'h11111111, 3'b010, 32'd0, 1'b1, L);
    xact("lw10c",  1'b0, 32'h10, 32'd0, 3'b010, 32'hDEAD55EF, 1'b0, L);
    xact("lw00",   1'b0, 32'h0,  32'd0, 3'b010, 32'h0BADF00D, 1'b0, L);

    // backpressure: response held, second request waits for IDLE
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hA5A5A5A5; req_funct3 = 3'b010;
    guard = 0;
    while (!cur_rsp_valid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("bp_first_data", cur_rsp_rdata, 32'hDEAD55EF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'd0, cur_rsp_valid}, 32'd1);
      check("bp_hold_rdata", cur_rsp_rdata, 32'hDEAD55EF);
      check("bp_hold_req_ready", {31'd0, cur_req_ready}, 32'd0);
      check("bp_hold_state", {30'd0, cur_dbg}, 32'd2);
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'd0, cur_rsp_valid}, 32'd0);
    check("bp_release_rdata", cur_rsp_rdata, 32'd0);
    check("bp_release_req_ready", {31'd0, cur_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_second_accepted", {31'd0, cur_req_ready}, 32'd0);
    check("bp_second_state", {30'd0, cur_dbg}, 32'd1);
    guard = 0;
    while (!cur_rsp_valid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("bp_second_err", {31'd0, cur_rsp_err}, 32'd0);
    @(posedge clk);
    #1;
    xact("lw14", 1'b0, 32'h14, 32'd0, 3'b010, 32'hA5A5A5A5, 1'b0, L);

    // reset during WAIT drops the store
    xact("sw20z", 1'b1, 32'h20, 32'h0, 3'b010, 32'd0, 1'b0, L);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rstw_in_wait", {30'd0, cur_dbg}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_state", {30'd0, cur_dbg}, 32'd0);
    check("rstw_rsp_valid", {31'd0, cur_rsp_valid}, 32'd0);
    check("rstw_rsp_rdata", cur_rsp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_req_ready", {31'd0, cur_req_ready}, 32'd1);
    xact("lw20", 1'b0, 32'h20, 32'd0, 3'b010, 32'h0, 1'b0, L);
    xact("lw10d", 1'b0, 32'h10, 32'd0, 3'b010, 32'hDEAD55EF, 1'b0, L);

    // latency of the WAIT_CYCLES=0 and WAIT_CYCLES=3 builds
    sel = 1;
    xact("w0_sw", 1'b1, 32'h8, 32'hCAFEF00D, 3'b010, 32'd0, 1'b0, 1);
    xact("w0_lw", 1'b0, 32'h8, 32'd0, 3'b010, 32'hCAFEF00D, 1'b0, 1);
    sel = 2;
    xact("w3_sw", 1'b1, 32'h8, 32'h600DCAFE, 3'b010, 32'd0, 1'b0, 4);
    xact("w3_lhu", 1'b0, 32'hA, 32'd0, 3'b101, 32'h0000600D, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
